ub_readout: RTL

- Read side of the unified buffer: drains stored accumulator results to the host/output port.
- On a start command it snapshots the four unified buffer words.
- It then streams a programmable window of them, with optional ReLU, over a valid/ready handshake.
- Sits beside unified_buffer in top_level_module and consumes its unified_mem_0..3 outputs.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/relu_clamp.sv | 14 +
 rtl/ub_readout.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU constants and the unified-buffer readout state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tpu_pkg;

  localparam int UB_DATA_W = 32;
  localparam int UB_DEPTH  = 4;
  localparam int UB_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } ub_rd_state_t;

endpackage

// File: rtl/relu_clamp.sv
// Clamps signed-negative words to zero when enabled; passes them through otherwise.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module relu_clamp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_data
);

  assign o_data = (i_en && i_data[DATA_W-1]) ? '0 : i_data;

endmodule

// File: rtl/ub_readout.sv
// Snapshots the unified buffer on start, then streams a window of it with optional ReLU.
// Latency: first word valid one cycle after start, then one word per accepted cycle.
// Backpressure: out_valid/out_ready; data, last and pointer hold while out_ready is low.
module ub_readout
  import tpu_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int DEPTH  = UB_DEPTH,
  parameter int ADDR_W = UB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] unified_mem_0,
  input  logic [DATA_W-1:0] unified_mem_1,
  input  logic [DATA_W-1:0] unified_mem_2,
  input  logic [DATA_W-1:0] unified_mem_3,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   L_DEPTH   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   L_REM_ONE = 1;
  localparam logic [ADDR_W-1:0] L_PTR_ONE = 1;

  ub_rd_state_t      r_state;
  ub_rd_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_shadow [DEPTH];
  logic [DATA_W-1:0] w_mem    [DEPTH];
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W:0]   r_rem, w_rem_nxt;
  logic              r_relu, w_relu_nxt;
  logic              w_load, w_err_nxt, w_fire, w_cnt_ok;
  logic [DATA_W-1:0] w_src_word, w_clamped, w_data_nxt;
  logic              w_valid_nxt, w_last_nxt;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid, r_out_last, r_busy, r_done, r_err;

  assign w_mem[0] = unified_mem_0;
  assign w_mem[1] = unified_mem_1;
  assign w_mem[2] = unified_mem_2;
  assign w_mem[3] = unified_mem_3;

  assign w_cnt_ok = (count != '0) && (count <= L_DEPTH);
  assign w_fire   = r_out_valid && out_ready;

  // Next-state, pointer/counter update and command acceptance
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_relu_nxt  = r_relu;
    w_load      = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_cnt_ok) begin
            w_load      = 1'b1;
            w_ptr_nxt   = start_addr;
            w_rem_nxt   = count;
            w_relu_nxt  = relu_en;
            w_state_nxt = STREAM;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      STREAM: begin
        if (w_fire) begin
          w_ptr_nxt = r_ptr + L_PTR_ONE;
          w_rem_nxt = r_rem - L_REM_ONE;
          if (r_rem == L_REM_ONE) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // On the start edge the shadow is not yet loaded, so read the live buffer instead
  assign w_src_word = w_load ? w_mem[w_ptr_nxt] : r_shadow[w_ptr_nxt];

  relu_clamp #(.DATA_W(DATA_W)) u_relu (
    .i_data (w_src_word),
    .i_en   (w_relu_nxt),
    .o_data (w_clamped)
  );

  assign w_valid_nxt = (w_state_nxt == STREAM);
  assign w_data_nxt  = w_valid_nxt ? w_clamped : '0;
  assign w_last_nxt  = w_valid_nxt && (w_rem_nxt == L_REM_ONE);

  // State, pointer, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_relu      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rem       <= w_rem_nxt;
      r_relu      <= w_relu_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
      r_busy      <= w_valid_nxt;
      r_done      <= (w_state_nxt == DONE);
      r_err       <= w_err_nxt;
    end
  end

  // Snapshot the unified buffer when a burst is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= w_mem[i];
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
